fwd_hazard_ctrl: RTL and testbench
==================================

// Module: fwd_hazard_ctrl
// PURPOSE
//  Parametrised forwarding and hazard controller for the pipelined RV32 core.
//  - Tracks in-flight destination tags internally: an EX slot plus FWD_STAGES
//    writeback stages.
//  - Resolves forwarding for NUM_SRC source operands; the youngest match wins.
//  - Generates load-use stalls and multi-cycle (MUL/DIV) EX holds.
//  - Sits between the ID/EX pipeline register and the EX operand muxes.
// PARAMETERS
//  XLEN        32  datapath width
//  NUM_SRC     2   source operands per instruction (rs1, rs2, [rs3])
//  FWD_STAGES  2   forwarding stages after EX (stage 0 = EX/MEM, stage 1 = MEM/WB, ...)
//  MC_LAT      4   total EX cycles of a multi-cycle op (>=1)
// PORTS
//  clk            in   1                clock, rising edge
//  rst            in   1                asynchronous reset, active-high
//  flush          in   1                kill instruction entering EX and any MC hold
//  id_valid       in   1                ID holds a valid instruction
//  id_rs          in   NUM_SRC*5        ID source register indices
//  id_rs_used     in   NUM_SRC          per-source "operand read" flags
//  id_rd          in   5                ID destination index
//  id_regwrite    in   1                ID instruction writes rd
//  id_memread     in   1                ID instruction is a load
//  id_multicycle  in   1                ID instruction is multi-cycle
//  stage_data     in   FWD_STAGES*XLEN  result value held in each forwarding stage
//  stall_id       out  1                hold PC and IF/ID this cycle
//  ex_hold        out  1                hold ID/EX; EX instruction stays
//  fwd_hit        out  NUM_SRC          operand i is taken from fwd_data[i]
//  fwd_data       out  NUM_SRC*XLEN     forwarded operand values
// BEHAVIOUR
//  Reset (async, rst=1)
//   - EX slot and all stages become bubbles (regwrite=0, rs_used=0).
//   - FSM goes to IDLE, cnt=0, and the latched operand copy clears.
//   - Outputs: stall_id=0, ex_hold=0, fwd_hit=0, fwd_data=0.
//  Pipeline advance (every clk edge)
//   - Stage k+1 <= stage k.
//   - Stage 0 <= EX slot, or a bubble if ex_hold=1.
//   - EX slot <= ID fields if !stall_id && !flush && id_valid; otherwise a
//     bubble. Exception: if ex_hold=1, the EX slot holds its value.
//  Forwarding (combinational on EX slot)
//   - For each source i with rs_used[i]=1 and rs[i]!=0, scan stages
//     0..FWD_STAGES-1.
//   - The first stage with regwrite=1 and rd==rs[i] sets fwd_hit[i]=1 and
//     fwd_data[i]=stage_data[k].
//   - A stage-0 entry with memread=1 is never a candidate; its data is not
//     ready yet.
//   - No match: fwd_hit[i]=0, fwd_data[i]=0.
//  Load-use stall (combinational)
//   - Condition: id_valid, an ID source used and nonzero, equal to the EX
//     slot rd, with EX regwrite=1 and memread=1.
//   - Response: stall_id=1, and exactly one bubble enters EX.
//  Multi-cycle FSM: states IDLE and BUSY; counter cnt of width clog2(MC_LAT).
//   - IDLE, EX slot multicycle, MC_LAT>1:
//     - ex_hold=1.
//     - fwd_hit/fwd_data are latched into the operand copy.
//     - Next state BUSY, cnt=MC_LAT-2.
//   - BUSY, cnt!=0:
//     - ex_hold=1 and cnt decrements.
//     - fwd outputs are driven from the latched copy.
//   - BUSY, cnt==0:
//     - ex_hold=0, outputs still come from the latched copy.
//     - Next state IDLE; the instruction leaves EX.
//   - Net effect: the instruction occupies EX for MC_LAT cycles with
//     MC_LAT-1 hold cycles. MC_LAT=1 never leaves IDLE.
//  Combined stall and priority
//   - stall_id = ex_hold | load_use.
//   - Priority: rst > flush > ex_hold > load_use.
//   - flush in BUSY returns the FSM to IDLE next edge; the EX slot becomes a bubble.
//  Simultaneous events
//   - A load-use condition during a hold is masked (stall_id is already 1).
//     It is re-evaluated after the hold against the new EX slot.
//  Register x0
//   - Never forwarded and never a stall source.
// TESTING
//  1. EX/MEM priority
//     - Stimulus: add x5 issued, then add x5 again, then sub x6,x5,x5
//       (stage0 = 0xA, stage1 = 0xB).
//     - Required: fwd_hit=2'b11, fwd_data=0xA for both operands.
//  2. Load-use
//     - Stimulus: lw x7, then add x8,x7,x0 in ID.
//     - Required: stall_id=1 for exactly 1 cycle; the add enters EX one cycle
//       late and forwards from stage 1 with fwd_hit[0]=1.
//  3. Multi-cycle hold
//     - Stimulus: MC_LAT=4, div enters EX.
//     - Required: ex_hold=1 for 3 cycles, then 0; fwd_data stays constant for
//       all 4 cycles even as stages drain.
//  4. Flush during BUSY
//     - Stimulus: flush=1 in the 2nd hold cycle.
//     - Required: next cycle FSM=IDLE, ex_hold=0, EX slot is a bubble
//       (fwd_hit=0).
//  5. x0 destination
//     - Stimulus: add x0 followed by an instruction reading x0.
//     - Required: fwd_hit=0, stall_id=0.
//  6. Async reset mid-BUSY
//     - Stimulus: assert rst between edges.
//     - Required: stall_id/ex_hold/fwd_hit drop to 0 immediately; the
//       previous producer no longer forwards after release.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller: tracks in-flight destinations (EX slot plus
// writeback stages), resolves operand forwarding, load-use stalls and MUL/DIV holds.
module fwd_hazard_ctrl #(
  parameter int XLEN       = 32,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int MC_LAT     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       id_valid,
  input  logic [NUM_SRC*5-1:0]       id_rs,
  input  logic [NUM_SRC-1:0]         id_rs_used,
  input  logic [4:0]                 id_rd,
  input  logic                       id_regwrite,
  input  logic                       id_memread,
  input  logic                       id_multicycle,
  input  logic [FWD_STAGES*XLEN-1:0] stage_data,
  output logic                       stall_id,
  output logic                       ex_hold,
  output logic [NUM_SRC-1:0]         fwd_hit,
  output logic [NUM_SRC*XLEN-1:0]    fwd_data
);

  localparam int CW = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;

  typedef struct packed {
    logic [NUM_SRC*5-1:0] rs;
    logic [NUM_SRC-1:0]   rs_used;
    logic [4:0]           rd;
    logic                 regwrite;
    logic                 memread;
    logic                 multicycle;
  } ex_slot_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } stage_t;

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} mc_state_t;

  // A load still in stage 0 has no data yet, so it can never be a forwarding source.
  function automatic logic stage_match(input stage_t s, input logic [4:0] src, input logic is_s0);
    return s.regwrite && (s.rd == src) && (src != 5'd0) && !(is_s0 && s.memread);
  endfunction

  ex_slot_t                  ex_q, ex_d;
  stage_t                    stg_q [FWD_STAGES];
  stage_t                    stg_d [FWD_STAGES];
  mc_state_t                 state_q, state_d, state_nxt_s;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [NUM_SRC-1:0]        lat_hit_q, lat_hit_d;
  logic [NUM_SRC*XLEN-1:0]   lat_data_q, lat_data_d;
  logic [NUM_SRC-1:0]        live_hit_s;
  logic [NUM_SRC*XLEN-1:0]   live_data_s;
  logic                      load_use_s, hold_s, use_lat_s, lat_en_s;

  // Live forwarding: scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    live_hit_s  = '0;
    live_data_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
        live_hit_s[i] = live_hit_s[i] |
                        (ex_q.rs_used[i] & stage_match(stg_q[k], ex_q.rs[i*5 +: 5], (k == 0)));
        live_data_s[i*XLEN +: XLEN] =
          (ex_q.rs_used[i] && stage_match(stg_q[k], ex_q.rs[i*5 +: 5], (k == 0)))
            ? stage_data[k*XLEN +: XLEN] : live_data_s[i*XLEN +: XLEN];
      end
    end
  end

  // Load-use detection between the ID instruction and a load sitting in EX.
  always_comb begin
    load_use_s = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      load_use_s = load_use_s | (id_valid & id_rs_used[i] & (id_rs[i*5 +: 5] != 5'd0) &
                                 (id_rs[i*5 +: 5] == ex_q.rd) & ex_q.regwrite & ex_q.memread);
    end
  end

  // Multi-cycle FSM next state and hold/latch controls.
  always_comb begin
    state_nxt_s = state_q;
    cnt_d       = cnt_q;
    hold_s      = 1'b0;
    use_lat_s   = 1'b0;
    lat_en_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_q.multicycle && (MC_LAT > 1)) begin
          hold_s      = 1'b1;
          lat_en_s    = 1'b1;
          state_nxt_s = BUSY;
          cnt_d       = CW'(MC_LAT - 2);
        end else begin
          cnt_d = '0;
        end
      end
      BUSY: begin
        use_lat_s = 1'b1;
        if (cnt_q != '0) begin
          hold_s = 1'b1;
          cnt_d  = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_d       = '0;
      end
    endcase
    state_d = flush ? IDLE : state_nxt_s;
    cnt_d   = flush ? '0 : cnt_d;
  end

  // Pipeline advance: EX slot capture/hold/bubble and stage shift.
  always_comb begin
    ex_d = '0;
    if (flush) begin
      ex_d = '0;
    end else if (hold_s) begin
      ex_d = ex_q;
    end else if (!stall_id && id_valid) begin
      ex_d = '{rs: id_rs, rs_used: id_rs_used, rd: id_rd, regwrite: id_regwrite,
               memread: id_memread, multicycle: id_multicycle};
    end else begin
      ex_d = '0;
    end
    stg_d[0] = hold_s ? stage_t'('0) : '{rd: ex_q.rd, regwrite: ex_q.regwrite, memread: ex_q.memread};
    for (int k = 1; k < FWD_STAGES; k++) begin
      stg_d[k] = stg_q[k-1];
    end
    lat_hit_d  = lat_en_s ? live_hit_s  : lat_hit_q;
    lat_data_d = lat_en_s ? live_data_s : lat_data_q;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q       <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      lat_hit_q  <= '0;
      lat_data_q <= '0;
      for (int k = 0; k < FWD_STAGES; k++) begin
        stg_q[k] <= '0;
      end
    end else begin
      ex_q       <= ex_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_hit_q  <= lat_hit_d;
      lat_data_q <= lat_data_d;
      for (int k = 0; k < FWD_STAGES; k++) begin
        stg_q[k] <= stg_d[k];
      end
    end
  end

  assign ex_hold  = hold_s;
  assign stall_id = hold_s | load_use_s;
  assign fwd_hit  = use_lat_s ? lat_hit_q  : live_hit_s;
  assign fwd_data = use_lat_s ? lat_data_q : live_data_s;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: a cycle-by-cycle vector table plus
// hand-written flush-in-BUSY and async-reset-in-BUSY sequences.
module tb_fwd_hazard_ctrl;
  localparam int XLEN = 32;

  logic        clk, rst, flush, id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd;
  logic        id_regwrite, id_memread, id_multicycle;
  logic [63:0] stage_data;
  logic        stall_id, ex_hold;
  logic [1:0]  fwd_hit;
  logic [63:0] fwd_data;

  int checks = 0;
  int failures = 0;

  fwd_hazard_ctrl #(.XLEN(32), .NUM_SRC(2), .FWD_STAGES(2), .MC_LAT(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_multicycle(id_multicycle), .stage_data(stage_data),
    .stall_id(stall_id), .ex_hold(ex_hold), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  rs1, rs2;
    logic [1:0]  used;
    logic [4:0]  rd;
    logic        rw, mr, mc;
    logic [31:0] sd0, sd1;
    logic        e_stall, e_hold;
    logic [1:0]  e_hit;
    logic [31:0] e_d0, e_d1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [1:0] used, input logic [4:0] rd, input logic rw,
                              input logic mr, input logic mc, input logic [31:0] sd0,
                              input logic [31:0] sd1, input logic e_stall, input logic e_hold,
                              input logic [1:0] e_hit, input logic [31:0] e_d0,
                              input logic [31:0] e_d1);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.used = used; r.rd = rd;
    r.rw = rw; r.mr = mr; r.mc = mc; r.sd0 = sd0; r.sd1 = sd1;
    r.e_stall = e_stall; r.e_hold = e_hold; r.e_hit = e_hit; r.e_d0 = e_d0; r.e_d1 = e_d1;
    return r;
  endfunction

  function automatic vec_t nop(input logic [31:0] sd0, input logic [31:0] sd1,
                               input logic e_stall, input logic e_hold, input logic [1:0] e_hit,
                               input logic [31:0] e_d0);
    return mk(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, sd0, sd1,
              e_stall, e_hold, e_hit, e_d0, 32'h0);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic e_stall, input logic e_hold,
                           input logic [1:0] e_hit, input logic [31:0] e_d0, input logic [31:0] e_d1);
    chk({nm, "_stall"}, {31'd0, stall_id}, {31'd0, e_stall});
    chk({nm, "_hold"},  {31'd0, ex_hold},  {31'd0, e_hold});
    chk({nm, "_hit"},   {30'd0, fwd_hit},  {30'd0, e_hit});
    chk({nm, "_d0"},    fwd_data[31:0],    e_d0);
    chk({nm, "_d1"},    fwd_data[63:32],   e_d1);
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [1:0] used, input logic [4:0] rd, input logic rw,
                        input logic mr, input logic mc);
    id_valid = v; id_rs = {rs2, rs1}; id_rs_used = used; id_rd = rd;
    id_regwrite = rw; id_memread = mr; id_multicycle = mc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    // EX/MEM priority: add x5; add x5; sub x6,x5,x5
    vecs.push_back(mk(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0));
    vecs.push_back(mk(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0));
    vecs.push_back(mk(1'b1, 5'd5, 5'd5, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 32'hA, 32'hB, 1'b0, 1'b0, 2'b11, 32'hA, 32'hA));
    vecs.push_back(nop(32'h5, 32'h6, 1'b0, 1'b0, 2'b00, 32'h0));
    vecs.push_back(nop(32'h5, 32'h6, 1'b0, 1'b0, 2'b00, 32'h0));
    // Load-use: lw x7; add x8,x7,x0 stalls one cycle, then forwards from stage 1
    vecs.push_back(mk(1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0));
    vecs.push_back(mk(1'b1, 5'd7, 5'd0, 2'b11, 5'd8, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0));
    vecs.push_back(mk(1'b1, 5'd7, 5'd0, 2'b11, 5'd8, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0));
    vecs.push_back(nop(32'h11, 32'h77, 1'b0, 1'b0, 2'b01, 32'h77));
    vecs.push_back(nop(32'h11, 32'h77, 1'b0, 1'b0, 2'b00, 32'h0));
    vecs.push_back(nop(32'h11, 32'h77, 1'b0, 1'b0, 2'b00, 32'h0));
    // x0: add x0 then reader of x0; lw x0 then reader of x0
    vecs.push_back(mk(1'b1, 5'd1, 5'd2, 2'b11, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0));
    vecs.push_back(mk(1'b1, 5'd0, 5'd0, 2'b11, 5'd9, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0));
    vecs.push_back(nop(32'h55, 32'h66, 1'b0, 1'b0, 2'b00, 32'h0));
    vecs.push_back(mk(1'b1, 5'd1, 5'd0, 2'b01, 5'd0, 1'b1, 1'b1, 1'b0, 32'h55, 32'h66, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0));
    vecs.push_back(mk(1'b1, 5'd0, 5'd0, 2'b11, 5'd12, 1'b1, 1'b0, 1'b0, 32'h55, 32'h66, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0));
    vecs.push_back(nop(32'h55, 32'h66, 1'b0, 1'b0, 2'b00, 32'h0));
    vecs.push_back(nop(32'h55, 32'h66, 1'b0, 1'b0, 2'b00, 32'h0));
    vecs.push_back(nop(32'h55, 32'h66, 1'b0, 1'b0, 2'b00, 32'h0));
    // Multi-cycle: add x3; div x10,x3,x4 holds 3 cycles with a frozen operand copy
    vecs.push_back(mk(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0));
    vecs.push_back(mk(1'b1, 5'd3, 5'd4, 2'b11, 5'd10, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0));
    vecs.push_back(nop(32'hD0, 32'hD1, 1'b1, 1'b1, 2'b01, 32'hD0));
    vecs.push_back(nop(32'hE0, 32'hE1, 1'b1, 1'b1, 2'b01, 32'hD0));
    vecs.push_back(nop(32'hF0, 32'hF1, 1'b1, 1'b1, 2'b01, 32'hD0));
    vecs.push_back(mk(1'b1, 5'd10, 5'd0, 2'b01, 5'd11, 1'b1, 1'b0, 1'b0, 32'h99, 32'h98, 1'b0, 1'b0, 2'b01, 32'hD0, 32'h0));
    vecs.push_back(nop(32'h1234, 32'h4321, 1'b0, 1'b0, 2'b01, 32'h1234));
    vecs.push_back(nop(32'h1234, 32'h4321, 1'b0, 1'b0, 2'b00, 32'h0));
    vecs.push_back(nop(32'h1234, 32'h4321, 1'b0, 1'b0, 2'b00, 32'h0));

    rst = 1'b1; flush = 1'b0; stage_data = 64'hDEAD_BEEF_CAFE_F00D;
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    #12;
    check_all("reset", 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      set_id(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].used, vecs[i].rd,
             vecs[i].rw, vecs[i].mr, vecs[i].mc);
      stage_data = {vecs[i].sd1, vecs[i].sd0};
      #3;
      check_all($sformatf("v%0d", i), vecs[i].e_stall, vecs[i].e_hold, vecs[i].e_hit,
                vecs[i].e_d0, vecs[i].e_d1);
      step();
    end

    // Flush in the second hold cycle kills the div
    set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0); step();
    set_id(1'b1, 5'd3, 5'd4, 2'b11, 5'd10, 1'b1, 1'b0, 1'b1); step();
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    stage_data = {32'hBB, 32'hAA}; #1;
    check_all("fl_idle", 1'b1, 1'b1, 2'b01, 32'hAA, 32'h0);
    step();
    flush = 1'b1; stage_data = {32'hDD, 32'hCC}; #1;
    check_all("fl_busy", 1'b1, 1'b1, 2'b01, 32'hAA, 32'h0);
    step();
    flush = 1'b0;
    set_id(1'b1, 5'd10, 5'd0, 2'b01, 5'd11, 1'b1, 1'b0, 1'b0);
    stage_data = {32'h6, 32'h5}; #1;
    check_all("fl_after", 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    step();
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0); #1;
    check_all("fl_nodiv", 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    step(); step(); step();

    // Async reset between edges while BUSY
    set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0); step();
    set_id(1'b1, 5'd3, 5'd4, 2'b11, 5'd10, 1'b1, 1'b0, 1'b1); step();
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    stage_data = {32'h0, 32'h33}; #1;
    check_all("rs_idle", 1'b1, 1'b1, 2'b01, 32'h33, 32'h0);
    step();
    stage_data = {32'h0, 32'h44}; #1;
    check_all("rs_busy", 1'b1, 1'b1, 2'b01, 32'h33, 32'h0);
    rst = 1'b1; #1;
    check_all("rs_async", 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    #1 rst = 1'b0; #1;
    check_all("rs_release", 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    set_id(1'b1, 5'd3, 5'd0, 2'b01, 5'd12, 1'b1, 1'b0, 1'b0);
    stage_data = {32'h77, 32'h66};
    step();
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0); #1;
    check_all("rs_after", 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
